nn_complex: RTL and testbench

//  - Single-bit complex-gate cell: OR-AND-INVERT (OAI22), w = ~((a | b) & (c | d)).
//  - Core is a structural CMOS-style (pull-up/pull-down) network.
//  - Result is registered so the cell drops into synchronous datapaths as a leaf

---
 rtl/nn_pkg.sv | 12 +
 rtl/nn_oai22_core.sv | 30 +++
 rtl/nn_complex.sv | 51 +++++
 tb/tb_nn_complex.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the nn_complex OAI22 cell: reset default and a
// reference function for benches.
package nn_pkg;

    localparam logic NN_RST_VAL = 1'b0;

    function automatic logic oai22_ref(input logic a, input logic b,
                                       input logic c, input logic d);
        return ~((a | b) & (c | d));
    endfunction

endpackage

// File: rtl/nn_oai22_core.sv
// Switch-level OAI22 core: w = ~((a | b) & (c | d)) as a complementary
// pull-up / pull-down transistor network between supply rails.
module nn_oai22_core (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output wire  w
);

    supply1 vdd;
    supply0 gnd;

    wire n_pd;
    wire n_ab;
    wire n_cd;

    // Pull-down: (a || b) in series with (c || d).
    nmos n_a (w,    n_pd, a);
    nmos n_b (w,    n_pd, b);
    nmos n_c (n_pd, gnd,  c);
    nmos n_d (n_pd, gnd,  d);

    // Pull-up: (a series b) in parallel with (c series d).
    pmos p_a (n_ab, vdd,  a);
    pmos p_b (w,    n_ab, b);
    pmos p_c (n_cd, vdd,  c);
    pmos p_d (w,    n_cd, d);

endmodule

// File: rtl/nn_complex.sv
// OAI22 leaf cell: switch-level core plus an optional async-reset output
// register so the cell drops into synchronous datapaths.
module nn_complex
    import nn_pkg::*;
#(
    parameter bit   REG_OUT = 1'b1,
    parameter logic RST_VAL = NN_RST_VAL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic w
);

    wire w_core;

    nn_oai22_core u_core (
        .a (a),
        .b (b),
        .c (c),
        .d (d),
        .w (w_core)
    );

    generate
        if (REG_OUT) begin : g_reg
            logic w_q;

            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of process order.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    w_q <= RST_VAL;
                end else begin
                    w_q <= w_core;
                end
            end

            assign w = w_q;
        end else begin : g_comb
            // Clock and reset are intentionally dead in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign w = w_core;
        end
    endgenerate

endmodule

// File: tb/tb_nn_complex.sv
// Self-checking bench for nn_complex: registered and combinational builds
// compared against a truth-table model of OAI22.
module tb_nn_complex;

    logic clk = 1'b0;
    logic rst_n;
    logic a, b, c, d;
    logic w_reg, w_comb;

    int vectors     = 0;
    int miscompares = 0;

    always #50 clk = ~clk;

    nn_complex #(.REG_OUT(1'b1)) dut_reg (
        .clk (clk), .rst_n (rst_n),
        .a (a), .b (b), .c (c), .d (d),
        .w (w_reg)
    );

    nn_complex #(.REG_OUT(1'b0)) dut_comb (
        .clk (clk), .rst_n (rst_n),
        .a (a), .b (b), .c (c), .d (d),
        .w (w_comb)
    );

    // Model: output high exactly when one OR group has both inputs low.
    function automatic logic model(input logic [3:0] v);
        return (v[3:2] == 2'b00) || (v[1:0] == 2'b00);
    endfunction

    task automatic drive(input logic [3:0] v);
        {a, b, c, d} = v;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(4'b1111);
        #10;
        vectors++;
        if (w_reg !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_immediate: got %b expected 0", w_reg);
        end
        vectors++;
        if (w_comb !== model(4'b1111)) begin
            miscompares++;
            $display("FAIL reset_comb_ignores_rst: got %b expected %b", w_comb, model(4'b1111));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (w_reg !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_first_edge: got %b expected 0", w_reg);
        end
    endtask

    task automatic test_partial;
        logic [3:0] seq [3];
        logic       exp [3];
        seq = '{4'b1101, 4'b1100, 4'b1110};
        exp = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(seq[i]);
            @(negedge clk);
            vectors++;
            if (w_reg !== exp[i]) begin
                miscompares++;
                $display("FAIL partial_%0d abcd=%b: got %b expected %b", i, seq[i], w_reg, exp[i]);
            end
        end
    endtask

    task automatic test_exhaustive;
        logic [3:0] prev;
        prev = {a, b, c, d};
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = i[3:0];
            drive(v);
            #1;
            vectors++;
            if (w_comb !== model(v)) begin
                miscompares++;
                $display("FAIL exh_comb abcd=%b: got %b expected %b", v, w_comb, model(v));
            end
            vectors++;
            if (w_reg !== model(prev)) begin
                miscompares++;
                $display("FAIL exh_hold abcd=%b: got %b expected %b", v, w_reg, model(prev));
            end
            @(negedge clk);
            vectors++;
            if (w_reg !== model(v)) begin
                miscompares++;
                $display("FAIL exh_reg abcd=%b: got %b expected %b", v, w_reg, model(v));
            end
            prev = v;
        end
    endtask

    // Each cycle applies a throwaway value first; only the value present at
    // the clock edge may reach the registered output.
    task automatic test_random;
        for (int i = 0; i < 200; i++) begin
            logic [3:0] junk, v;
            junk = 4'($urandom);
            v    = 4'($urandom);
            drive(junk);
            #1;
            vectors++;
            if (w_comb !== model(junk)) begin
                miscompares++;
                $display("FAIL rand_comb abcd=%b: got %b expected %b", junk, w_comb, model(junk));
            end
            #10;
            drive(v);
            @(negedge clk);
            vectors++;
            if (w_reg !== model(v)) begin
                miscompares++;
                $display("FAIL rand_reg abcd=%b junk=%b: got %b expected %b", v, junk, w_reg, model(v));
            end
        end
    endtask

    task automatic test_async_reset;
        drive(4'b0011);
        @(negedge clk);
        vectors++;
        if (w_reg !== 1'b1) begin
            miscompares++;
            $display("FAIL async_pre: got %b expected 1", w_reg);
        end
        #10;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (w_reg !== 1'b0) begin
            miscompares++;
            $display("FAIL async_immediate: got %b expected 0", w_reg);
        end
        vectors++;
        if (w_comb !== 1'b1) begin
            miscompares++;
            $display("FAIL async_comb_ignores_rst: got %b expected 1", w_comb);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (w_reg !== 1'b0) begin
            miscompares++;
            $display("FAIL async_hold: got %b expected 0", w_reg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (w_reg !== 1'b1) begin
            miscompares++;
            $display("FAIL async_release_load: got %b expected 1", w_reg);
        end
    endtask

    // Inputs toggle on their own periods, offset from the clock edges.
    task automatic test_toggle;
        @(posedge clk);
        #20;
        fork
            repeat (100) begin #1000; a = ~a; end
            repeat (66)  begin #1500; b = ~b; end
            repeat (50)  begin #2000; c = ~c; end
            repeat (40)  begin #2500; d = ~d; end
            begin
                logic exp;
                repeat (990) begin
                    @(posedge clk);
                    exp = model({a, b, c, d});
                    #1;
                    vectors++;
                    if (w_reg !== exp) begin
                        miscompares++;
                        $display("FAIL toggle_post_edge t=%0t: got %b expected %b", $time, w_reg, exp);
                    end
                    @(negedge clk);
                    vectors++;
                    if (w_reg !== exp) begin
                        miscompares++;
                        $display("FAIL toggle_reg t=%0t: got %b expected %b", $time, w_reg, exp);
                    end
                    vectors++;
                    if (w_comb !== model({a, b, c, d})) begin
                        miscompares++;
                        $display("FAIL toggle_comb t=%0t: got %b expected %b", $time, w_comb, model({a, b, c, d}));
                    end
                end
            end
        join
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_partial();
        test_exhaustive();
        test_random();
        test_async_reset();
        test_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
